// File: rtl/mine_field_gen_if.sv
// Purpose: groups the controller-facing signals of mine_field_gen.
//  Controller -> generator: in_start, in_seed, in_mult, in_increment, in_safe_cell
//  Generator -> controller: out_mines, out_count, out_busy, out_done, out_error
//  master = game controller side, slave = generator side.
interface mine_field_gen_if #(
   parameter int unsigned ROWS      = 5,
   parameter int unsigned COLS      = 5,
   parameter int unsigned NUM_MINES = 5,
   parameter int unsigned SEED_W    = 16
);
   localparam int unsigned CELLS = ROWS * COLS;
   localparam int unsigned IDX_W = $clog2(CELLS);
   localparam int unsigned CNT_W = $clog2(NUM_MINES + 1);

   logic              in_start;
   logic [SEED_W-1:0] in_seed;
   logic [SEED_W-1:0] in_mult;
   logic [SEED_W-1:0] in_increment;
   logic [IDX_W-1:0]  in_safe_cell;
   logic [CELLS-1:0]  out_mines;
   logic [CNT_W-1:0]  out_count;
   logic              out_busy;
   logic              out_done;
   logic              out_error;

   modport master (
      output in_start, in_seed, in_mult, in_increment, in_safe_cell,
      input  out_mines, out_count, out_busy, out_done, out_error
   );

   modport slave (
      input  in_start, in_seed, in_mult, in_increment, in_safe_cell,
      output out_mines, out_count, out_busy, out_done, out_error
   );
endinterface

// File: rtl/mine_field_gen.sv
// Purpose: places NUM_MINES distinct mines on a ROWS x COLS board using an
//  LCG X <= A*X + C (mod 2^SEED_W); one draw per cycle, candidate cell is the
//  top IDX_W bits of the new X. Duplicates, out-of-range cells and the safe
//  cell are redrawn; the run aborts after MAX_TRIES draws.
// Ports:
//  in_clka  - clock, rising edge
//  in_reset - synchronous active-high reset
//  bus      - slave side of mine_field_gen_if (start/seed/mult/increment/
//             safe_cell in; mines/count/busy/done/error out)
module mine_field_gen #(
   parameter int unsigned ROWS      = 5,
   parameter int unsigned COLS      = 5,
   parameter int unsigned NUM_MINES = 5,
   parameter int unsigned SEED_W    = 16,
   parameter int unsigned MAX_TRIES = 64
) (
   input logic              in_clka,
   input logic              in_reset,
   mine_field_gen_if.slave  bus
);
   localparam int unsigned CELLS  = ROWS * COLS;
   localparam int unsigned IDX_W  = $clog2(CELLS);
   localparam int unsigned CNT_W  = $clog2(NUM_MINES + 1);
   localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
   localparam int unsigned PROD_W = 2 * SEED_W;

   typedef enum logic [1:0] {ST_IDLE, ST_DRAW, ST_DONE} state_e;

   state_e            state_q, state_d;
   logic [SEED_W-1:0] x_q, x_d;
   logic [SEED_W-1:0] mult_q, mult_d;
   logic [SEED_W-1:0] inc_q, inc_d;
   logic [IDX_W-1:0]  safe_q, safe_d;
   logic [CELLS-1:0]  mines_q, mines_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [TRY_W-1:0]  tries_q, tries_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   logic [SEED_W-1:0] x_next_c;
   logic [IDX_W-1:0]  idx_c;
   logic              in_range_c;
   logic              occupied_c;
   logic              accept_c;

   // Next LCG value and candidate evaluation; low bits of the full product kept.
   always_comb begin
      x_next_c   = SEED_W'(PROD_W'(mult_q) * PROD_W'(x_q)) + inc_q;
      idx_c      = x_next_c[SEED_W-1 -: IDX_W];
      in_range_c = 1'b0;
      occupied_c = 1'b0;
      // Decoding via a loop keeps the lookup in bounds when idx_c >= CELLS.
      for (int unsigned i = 0; i < CELLS; i++) begin
         if (idx_c == IDX_W'(i)) begin
            in_range_c = 1'b1;
            occupied_c = mines_q[i];
         end
      end
      accept_c = in_range_c && (idx_c != safe_q) && !occupied_c;
   end

   // Next-state and output logic.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      mult_d  = mult_q;
      inc_d   = inc_q;
      safe_d  = safe_q;
      mines_d = mines_q;
      count_d = count_q;
      tries_d = tries_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      error_d = error_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.in_start) begin
               x_d     = bus.in_seed;
               mult_d  = bus.in_mult;
               inc_d   = bus.in_increment;
               safe_d  = bus.in_safe_cell;
               mines_d = '0;
               count_d = '0;
               tries_d = '0;
               error_d = 1'b0;
               busy_d  = 1'b1;
               state_d = ST_DRAW;
            end
         end
         ST_DRAW: begin
            x_d     = x_next_c;
            tries_d = tries_q + TRY_W'(1);
            if (accept_c) begin
               mines_d = mines_q | (CELLS'(1) << idx_c);
               count_d = count_q + CNT_W'(1);
            end
            // Success is tested first so it wins over a coincident budget expiry.
            if (accept_c && (count_q + CNT_W'(1) == CNT_W'(NUM_MINES))) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else if (tries_d == TRY_W'(MAX_TRIES)) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               error_d = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge in_clka) begin
      if (in_reset) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         mult_q  <= '0;
         inc_q   <= '0;
         safe_q  <= '0;
         mines_q <= '0;
         count_q <= '0;
         tries_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         mult_q  <= mult_d;
         inc_q   <= inc_d;
         safe_q  <= safe_d;
         mines_q <= mines_d;
         count_q <= count_d;
         tries_q <= tries_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign bus.out_mines = mines_q;
   assign bus.out_count = count_q;
   assign bus.out_busy  = busy_q;
   assign bus.out_done  = done_q;
   assign bus.out_error = error_q;
endmodule
